get_reg: RTL and testbench
==========================

# get_reg

Register-name lookup for the RISC-V decoder/executer debug path. Converts a general-purpose register index into its printable ASCII name, either ABI (`zero`, `ra`, `a0`, …) or numeric (`x0`..`x31`). The register-dump and trace logic uses it to label each register. It is a single-cycle registered lookup with a valid qualifier.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  request strobe; `in_idx`/`in_numeric` are sampled when high.
- `in_idx`  in  6  register index; 0–31 valid, 32–63 out of range.
- `in_numeric`  in  1  0 = ABI name, 1 = numeric `x<n>` name.
- `out_valid`  out  1  high for exactly the cycle after each accepted request.
- `out_name`  out  32  ASCII name, right-justified, unused upper bytes 0x00.
- `out_len`  out  3  character count of `out_name` (1–4).

## Operation
- Encoding: last character sits in bits [7:0], the preceding one in [15:8], and so on.
  - `"zero"` = 0x7A65726F.
  - `"ra"` = 0x00007261.
  - `"s10"` = 0x00733130.
- ABI map (`in_numeric`=0):
  - 0 `zero`, 1 `ra`, 2 `sp`, 3 `gp`, 4 `tp`.
  - 5–7 `t0`–`t2`.
  - 8 `s0` (never `fp`), 9 `s1`.
  - 10–17 `a0`–`a7`.
  - 18–27 `s2`–`s11`.
  - 28–31 `t3`–`t6`.
- Numeric map (`in_numeric`=1):
  - `x` followed by the decimal index, no leading zero.
  - Indices 0–9 give 2 chars; 10–31 give 3 chars.
  - Examples: `x0` = 0x00007830, `x31` = 0x00783331.
- Out of range (`in_idx` ≥ 32), either mode: `out_name` = `"bad"` (0x00626164), `out_len` = 3.
- `out_len` always equals the number of nonzero bytes in `out_name`.
- Purely combinational lookup feeding output registers; no other state.

## Timing
- Reset (`rst_n` low) immediately forces `out_valid`=0, `out_name`=0, `out_len`=0. This holds regardless of the clock and continues until the first edge after release.
- Latency: 1 cycle. Request sampled at edge N produces `out_valid`=1 with the matching name after edge N, for one cycle only.
- Throughput: one request per cycle. Back-to-back requests produce back-to-back results in order.
- No backpressure; results are not stalled or queued.
- `in_valid` low at an edge:
  - `out_valid` returns to 0.
  - `out_name`/`out_len` hold their last values.
- Reset asserted while a request is pending: the request is discarded, and no `out_valid` pulse follows reset release.
- `in_numeric` is sampled per request; it may change every cycle.

## Test plan
- Reset with `rst_n`=0 mid-stream → `out_valid`/`out_name`/`out_len` = 0 immediately; request held through reset gives no pulse after release.
- Sweep idx 0–31 ABI mode, back-to-back → one result per cycle, latency 1:
  - 0 → 0x7A65726F, len 4.
  - 8 → `s0` = 0x00007330.
  - 27 → `s11` = 0x00733131.
  - 31 → `t6` = 0x00007436.
- Sweep idx 0–31 numeric mode:
  - 9 → 0x00007839, len 2.
  - 10 → 0x00783130, len 3.
  - 31 → 0x00783331.
- Idx 32 and 63, both modes → 0x00626164, len 3.
- Alternate `in_numeric` every cycle with idx 10 → `a0` (0x00006130) and `x10` (0x00783130) alternate.
- Request then `in_valid`=0 for 3 cycles → `out_valid` pulses once; name/len hold thereafter.

Source files
------------

// File: rtl/get_reg.sv
// Register-name lookup: maps a GPR index to its right-justified ASCII ABI or numeric name.
// The combinational lookup feeds output registers qualified by a one-cycle valid.
module get_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [5:0]  in_idx,
    input  logic        in_numeric,
    output logic        out_valid,
    output logic [31:0] out_name,
    output logic [2:0]  out_len
);

    localparam logic [7:0] ChZero = 8'h30;
    localparam logic [7:0] ChA    = 8'h61;
    localparam logic [7:0] ChS    = 8'h73;
    localparam logic [7:0] ChT    = 8'h74;
    localparam logic [7:0] ChX    = 8'h78;

    logic [31:0] name_d;
    logic [2:0]  len_d;
    logic [7:0]  idx8;
    logic [7:0]  tens;
    logic [7:0]  ones;

    always_comb begin
        name_d = '0;
        len_d  = 3'd2;
        idx8   = {3'b000, in_idx[4:0]};
        tens   = ChZero;
        ones   = ChZero;
        if (in_idx[5]) begin
            name_d = 32'h0062_6164;
            len_d  = 3'd3;
        end else if (in_numeric) begin
            if (idx8 < 8'd10) begin
                name_d = {16'h0000, ChX, ChZero + idx8};
            end else begin
                // Split the two-digit index without a divider.
                if (idx8 >= 8'd30) begin
                    tens = ChZero + 8'd3;
                    ones = ChZero + idx8 - 8'd30;
                end else if (idx8 >= 8'd20) begin
                    tens = ChZero + 8'd2;
                    ones = ChZero + idx8 - 8'd20;
                end else begin
                    tens = ChZero + 8'd1;
                    ones = ChZero + idx8 - 8'd10;
                end
                name_d = {8'h00, ChX, tens, ones};
                len_d  = 3'd3;
            end
        end else begin
            if (idx8 == 8'd0) begin
                name_d = 32'h7A65_726F;
                len_d  = 3'd4;
            end else if (idx8 == 8'd1) begin
                name_d = 32'h0000_7261;
            end else if (idx8 == 8'd2) begin
                name_d = 32'h0000_7370;
            end else if (idx8 == 8'd3) begin
                name_d = 32'h0000_6770;
            end else if (idx8 == 8'd4) begin
                name_d = 32'h0000_7470;
            end else if (idx8 < 8'd8) begin
                name_d = {16'h0000, ChT, ChZero + idx8 - 8'd5};
            end else if (idx8 < 8'd10) begin
                // x8 is always s0, never fp.
                name_d = {16'h0000, ChS, ChZero + idx8 - 8'd8};
            end else if (idx8 < 8'd18) begin
                name_d = {16'h0000, ChA, ChZero + idx8 - 8'd10};
            end else if (idx8 < 8'd26) begin
                name_d = {16'h0000, ChS, ChZero + idx8 - 8'd16};
            end else if (idx8 < 8'd28) begin
                name_d = {8'h00, ChS, ChZero + 8'd1, ChZero + idx8 - 8'd26};
                len_d  = 3'd3;
            end else begin
                name_d = {16'h0000, ChT, ChZero + idx8 - 8'd25};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_name  <= '0;
            out_len   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_name <= name_d;
                out_len  <= len_d;
            end
        end
    end

endmodule

// File: tb/tb_get_reg.sv
// Directed self-checking bench for get_reg: reset, both name sweeps, out-of-range,
// per-cycle mode switching and hold behaviour.
module tb_get_reg;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [5:0]  in_idx;
    logic        in_numeric;
    logic        out_valid;
    logic [31:0] out_name;
    logic [2:0]  out_len;

    int checks;
    int failures;

    localparam logic [31:0] ABI [32] = '{
        "zero", "ra", "sp", "gp", "tp", "t0", "t1", "t2",
        "s0", "s1", "a0", "a1", "a2", "a3", "a4", "a5",
        "a6", "a7", "s2", "s3", "s4", "s5", "s6", "s7",
        "s8", "s9", "s10", "s11", "t3", "t4", "t5", "t6"
    };
    localparam logic [31:0] NUM [32] = '{
        "x0", "x1", "x2", "x3", "x4", "x5", "x6", "x7",
        "x8", "x9", "x10", "x11", "x12", "x13", "x14", "x15",
        "x16", "x17", "x18", "x19", "x20", "x21", "x22", "x23",
        "x24", "x25", "x26", "x27", "x28", "x29", "x30", "x31"
    };
    localparam logic [31:0] BAD = 32'h0062_6164;

    get_reg dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_idx     (in_idx),
        .in_numeric (in_numeric),
        .out_valid  (out_valid),
        .out_name   (out_name),
        .out_len    (out_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] name_len(input logic [31:0] n);
        logic [2:0] c;
        c = 3'd0;
        for (int b = 0; b < 4; b++) if (n[8*b +: 8] != 8'h00) c = c + 3'd1;
        return c;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_idx = '0; in_numeric = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_name !== 32'h0 || out_len !== 3'd0) begin
            failures++;
            $display("FAIL reset_initial: got v=%b name=%h len=%0d want v=0 name=0 len=0",
                     out_valid, out_name, out_len);
        end
        @(negedge clk); rst_n = 1'b1;
        // Make outputs nonzero so the mid-stream reset is observable.
        in_valid = 1'b1; in_idx = 6'd0; in_numeric = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_name !== 32'h7A65_726F || out_len !== 3'd4) begin
            failures++;
            $display("FAIL reset_pre_req: got v=%b name=%h len=%0d want v=1 name=7a65726f len=4",
                     out_valid, out_name, out_len);
        end
        in_idx = 6'd27;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_name !== 32'h0 || out_len !== 3'd0) begin
            failures++;
            $display("FAIL reset_async: got v=%b name=%h len=%0d want v=0 name=0 len=0",
                     out_valid, out_name, out_len);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_name !== 32'h0 || out_len !== 3'd0) begin
            failures++;
            $display("FAIL reset_no_pulse: got v=%b name=%h len=%0d want v=0 name=0 len=0",
                     out_valid, out_name, out_len);
        end
    endtask

    task automatic test_sweep(input logic numeric);
        logic [31:0] exp;
        for (int i = 0; i <= 32; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp = numeric ? NUM[i-1] : ABI[i-1];
                checks++;
                if (out_valid !== 1'b1 || out_name !== exp || out_len !== name_len(exp)) begin
                    failures++;
                    $display("FAIL sweep_%s_%0d: got v=%b name=%h len=%0d want v=1 name=%h len=%0d",
                             numeric ? "num" : "abi", i - 1, out_valid, out_name, out_len,
                             exp, name_len(exp));
                end
            end
            if (i < 32) begin
                in_valid = 1'b1; in_idx = 6'(i); in_numeric = numeric;
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_out_of_range;
        logic [5:0] idxs [4];
        logic       modes [4];
        idxs  = '{6'd32, 6'd63, 6'd32, 6'd63};
        modes = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_name !== BAD || out_len !== 3'd3) begin
                    failures++;
                    $display("FAIL oob_%0d_m%0b: got v=%b name=%h len=%0d want v=1 name=%h len=3",
                             idxs[i-1], modes[i-1], out_valid, out_name, out_len, BAD);
                end
            end
            if (i < 4) begin
                in_valid = 1'b1; in_idx = idxs[i]; in_numeric = modes[i];
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_alternate;
        logic [31:0] exp;
        logic [2:0]  elen;
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp  = ((i - 1) % 2 == 1) ? 32'h0078_3130 : 32'h0000_6130;
                elen = ((i - 1) % 2 == 1) ? 3'd3 : 3'd2;
                checks++;
                if (out_valid !== 1'b1 || out_name !== exp || out_len !== elen) begin
                    failures++;
                    $display("FAIL alternate_%0d: got v=%b name=%h len=%0d want v=1 name=%h len=%0d",
                             i - 1, out_valid, out_name, out_len, exp, elen);
                end
            end
            if (i < 6) begin
                in_valid = 1'b1; in_idx = 6'd10; in_numeric = (i % 2 == 1);
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_hold;
        @(negedge clk);
        in_valid = 1'b1; in_idx = 6'd5; in_numeric = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_name !== 32'h0000_7430 || out_len !== 3'd2) begin
            failures++;
            $display("FAIL hold_pulse: got v=%b name=%h len=%0d want v=1 name=00007430 len=2",
                     out_valid, out_name, out_len);
        end
        in_valid = 1'b0; in_idx = 6'd0; in_numeric = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || out_name !== 32'h0000_7430 || out_len !== 3'd2) begin
                failures++;
                $display("FAIL hold_idle_%0d: got v=%b name=%h len=%0d want v=0 name=00007430 len=2",
                         i, out_valid, out_name, out_len);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_sweep(1'b0);
        test_sweep(1'b1);
        test_out_of_range();
        test_alternate();
        test_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
